// File: rtl/ccr_pkg.sv
// Shared flag index constants, default sizes and operation decode for the CCR save stack.
package ccr_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int DEFAULT_FLAG_W = 4;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_POP,
        OP_PUSH,
        OP_WRITE
    } ccr_op_e;

    // Only one operation per cycle: return-from-interrupt beats interrupt beats flag write.
    function automatic ccr_op_e decode_op(input logic rti, input logic intr, input logic wen);
        if (rti)
            return OP_POP;
        else if (intr)
            return OP_PUSH;
        else if (wen)
            return OP_WRITE;
        else
            return OP_IDLE;
    endfunction

endpackage

// File: rtl/ccr_lifo.sv
// Save-slot LIFO for nested interrupts; pushes when full and pops when empty are dropped.
module ccr_lifo
    import ccr_pkg::*;
#(
    parameter int W     = DEFAULT_FLAG_W,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int DW   = $clog2(DEPTH + 1),
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  slot [DEPTH];
    logic [DW-1:0] cnt;
    logic [DW-1:0] top_cnt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign top_cnt = cnt - DW'(1);
    assign wr_idx  = cnt[IW-1:0];
    assign rd_idx  = top_cnt[IW-1:0];

    assign depth = cnt;
    assign full  = (cnt == DW'(DEPTH));
    assign empty = (cnt == '0);

    // Gate the read when empty so a wrapped index never reaches a nonexistent slot.
    assign dout = empty ? '0 : slot[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                slot[i] <= '0;
        end else if (pop) begin
            if (!empty)
                cnt <= cnt - DW'(1);
        end else if (push) begin
            if (!full) begin
                slot[wr_idx] <= din;
                cnt          <= cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/ccr_stack.sv
// Condition code register with a nested-interrupt save stack.
// Optional macro CCR_STACK_ERR_EN enables the sticky overflow/underflow flags and err_clr.
module ccr_stack
    import ccr_pkg::*;
#(
    parameter int FLAG_W = DEFAULT_FLAG_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RTI_en,
    input  logic                       interruptD,
    input  logic                       ccr_wen,
    input  logic [FLAG_W-1:0]          flag_mask,
    input  logic [FLAG_W-1:0]          ALU_Flags,
    input  logic                       err_clr,
    output logic [FLAG_W-1:0]          ccr_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    ccr_op_e     op;
    logic [FLAG_W-1:0] ccr_q;
    logic [FLAG_W-1:0] lifo_dout;
    logic        do_push;
    logic        do_pop;

    assign op      = decode_op(RTI_en, interruptD, ccr_wen);
    assign do_push = (op == OP_PUSH);
    assign do_pop  = (op == OP_POP);

    ccr_lifo #(
        .W     (FLAG_W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .din   (ccr_q),
        .dout  (lifo_dout),
        .depth (depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ccr_q <= '0;
        end else begin
            case (op)
                OP_POP: begin
                    if (!stack_empty)
                        ccr_q <= lifo_dout;
                end
                OP_WRITE: ccr_q <= (ccr_q & ~flag_mask) | (ALU_Flags & flag_mask);
                default:  ccr_q <= ccr_q;
            endcase
        end
    end

    assign ccr_out = ccr_q;

`ifdef CCR_STACK_ERR_EN
    logic ovf_q;
    logic unf_q;
    logic ovf_set;
    logic unf_set;

    assign ovf_set = do_push && stack_full;
    assign unf_set = do_pop && stack_empty;

    // A new error event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (err_clr)
                ovf_q <= 1'b0;
            if (unf_set)
                unf_q <= 1'b1;
            else if (err_clr)
                unf_q <= 1'b0;
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf_err        = 1'b0;
    assign unf_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ccr_stack.sv
// Self-checking bench for ccr_stack: directed scenarios plus a randomized run against a queue model.
module tb_ccr_stack;

    localparam int FLAG_W = 4;
    localparam int DEPTH  = 4;
    localparam int DW     = $clog2(DEPTH + 1);
`ifdef CCR_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              RTI_en = 1'b0;
    logic              interruptD = 1'b0;
    logic              ccr_wen = 1'b0;
    logic [FLAG_W-1:0] flag_mask = '0;
    logic [FLAG_W-1:0] ALU_Flags = '0;
    logic              err_clr = 1'b0;
    logic [FLAG_W-1:0] ccr_out;
    logic [DW-1:0]     depth;
    logic              stack_full;
    logic              stack_empty;
    logic              ovf_err;
    logic              unf_err;

    int checks = 0;
    int errors = 0;

    ccr_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .RTI_en      (RTI_en),
        .interruptD  (interruptD),
        .ccr_wen     (ccr_wen),
        .flag_mask   (flag_mask),
        .ALU_Flags   (ALU_Flags),
        .err_clr     (err_clr),
        .ccr_out     (ccr_out),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    // Reference model: the saved CCRs are a plain queue, newest at the back.
    logic [FLAG_W-1:0] m_ccr = '0;
    logic [FLAG_W-1:0] m_stack[$];
    bit                m_ovf = 1'b0;
    bit                m_unf = 1'b0;

    function automatic int m_depth();
        return m_stack.size();
    endfunction

    task automatic model_step();
        bit ovf_ev = 1'b0;
        bit unf_ev = 1'b0;
        if (reset) begin
            m_ccr = '0;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        if (RTI_en) begin
            if (m_stack.size() > 0) m_ccr = m_stack.pop_back();
            else unf_ev = 1'b1;
        end else if (interruptD) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_ccr);
            else ovf_ev = 1'b1;
        end else if (ccr_wen) begin
            for (int i = 0; i < FLAG_W; i++)
                if (flag_mask[i]) m_ccr[i] = ALU_Flags[i];
        end
        if (ERR_EN) begin
            if (ovf_ev) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
            if (unf_ev) m_unf = 1'b1; else if (err_clr) m_unf = 1'b0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; RTI_en = 0; interruptD = 0; ccr_wen = 0; err_clr = 0;
        flag_mask = '0; ALU_Flags = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; cycle(); reset = 0;
    endtask

    task automatic write_ccr(input logic [FLAG_W-1:0] v);
        idle_inputs();
        ccr_wen = 1; flag_mask = '1; ALU_Flags = v; cycle(); idle_inputs();
    endtask

    task automatic push_once();
        idle_inputs(); interruptD = 1; cycle(); idle_inputs();
    endtask

    task automatic pop_once();
        idle_inputs(); RTI_en = 1; cycle(); idle_inputs();
    endtask

    task automatic test_reset();
        RTI_en = 1; interruptD = 1; ccr_wen = 1; flag_mask = '1; ALU_Flags = 4'hF;
        reset = 1; cycle(); idle_inputs();
        checks++; if (ccr_out !== 4'h0) begin errors++; $display("FAIL reset_ccr got %h exp 0", ccr_out); end
        checks++; if (depth !== 0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth); end
        checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", stack_empty, stack_full); end
        checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL reset_err ovf=%b unf=%b exp 0/0", ovf_err, unf_err); end
    endtask

    task automatic test_flag_write();
        do_reset();
        ccr_wen = 1; flag_mask = 4'b1111; ALU_Flags = 4'b1010; cycle(); idle_inputs();
        checks++; if (ccr_out !== 4'b1010) begin errors++; $display("FAIL wen_full got %b exp 1010", ccr_out); end
        checks++; if (depth !== 0 || stack_empty !== 1'b1) begin errors++; $display("FAIL wen_depth depth=%0d empty=%b exp 0/1", depth, stack_empty); end
        ccr_wen = 1; flag_mask = 4'b0011; ALU_Flags = 4'b0101; cycle(); idle_inputs();
        checks++; if (ccr_out !== 4'b1001) begin errors++; $display("FAIL wen_mask got %b exp 1001", ccr_out); end
        for (int k = 0; k < 8; k++) begin
            ccr_wen = 1; flag_mask = 4'($urandom); ALU_Flags = 4'($urandom); cycle(); idle_inputs();
            checks++; if (ccr_out !== m_ccr) begin errors++; $display("FAIL wen_rand got %h exp %h", ccr_out, m_ccr); end
        end
    endtask

    task automatic test_nested();
        do_reset();
        write_ccr(4'h3);
        push_once();
        checks++; if (depth !== 1 || ccr_out !== 4'h3) begin errors++; $display("FAIL nest_push1 depth=%0d ccr=%h exp 1/3", depth, ccr_out); end
        write_ccr(4'h5);
        push_once();
        checks++; if (depth !== 2 || ccr_out !== 4'h5) begin errors++; $display("FAIL nest_push2 depth=%0d ccr=%h exp 2/5", depth, ccr_out); end
        write_ccr(4'hF);
        pop_once();
        checks++; if (depth !== 1 || ccr_out !== 4'h5) begin errors++; $display("FAIL nest_pop1 depth=%0d ccr=%h exp 1/5", depth, ccr_out); end
        pop_once();
        checks++; if (depth !== 0 || ccr_out !== 4'h3) begin errors++; $display("FAIL nest_pop2 depth=%0d ccr=%h exp 0/3", depth, ccr_out); end
    endtask

    task automatic test_overflow();
        logic [FLAG_W-1:0] vals[5];
        do_reset();
        for (int k = 0; k < 5; k++) begin
            vals[k] = 4'($urandom);
            write_ccr(vals[k]);
            push_once();
        end
        checks++; if (depth !== DW'(DEPTH) || stack_full !== 1'b1) begin errors++; $display("FAIL ovf_full depth=%0d full=%b exp %0d/1", depth, stack_full, DEPTH); end
        checks++; if (ovf_err !== ERR_EN) begin errors++; $display("FAIL ovf_flag got %b exp %b", ovf_err, ERR_EN); end
        checks++; if (ccr_out !== vals[4]) begin errors++; $display("FAIL ovf_ccr got %h exp %h", ccr_out, vals[4]); end
        write_ccr(4'($urandom));
        for (int k = 3; k >= 0; k--) begin
            pop_once();
            checks++; if (ccr_out !== vals[k] || depth !== DW'(k)) begin errors++; $display("FAIL ovf_pop%0d ccr=%h depth=%0d exp %h/%0d", k, ccr_out, depth, vals[k], k); end
        end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", stack_empty); end
    endtask

    task automatic test_underflow();
        do_reset();
        write_ccr(4'h6);
        pop_once();
        checks++; if (ccr_out !== 4'h6 || depth !== 0) begin errors++; $display("FAIL unf_hold ccr=%h depth=%0d exp 6/0", ccr_out, depth); end
        checks++; if (unf_err !== ERR_EN) begin errors++; $display("FAIL unf_set got %b exp %b", unf_err, ERR_EN); end
        err_clr = 1; cycle(); idle_inputs();
        checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL unf_clr got %b exp 0", unf_err); end
        err_clr = 1; RTI_en = 1; cycle(); idle_inputs();
        checks++; if (unf_err !== ERR_EN) begin errors++; $display("FAIL unf_clr_race got %b exp %b", unf_err, ERR_EN); end
        write_ccr(4'hA);
        push_once();
        write_ccr(4'h1);
        RTI_en = 1; interruptD = 1; ccr_wen = 1; flag_mask = 4'hF; ALU_Flags = 4'hC; cycle(); idle_inputs();
        checks++; if (ccr_out !== 4'hA || depth !== 0) begin errors++; $display("FAIL pop_only ccr=%h depth=%0d exp a/0", ccr_out, depth); end
        write_ccr(4'h2);
        interruptD = 1; ccr_wen = 1; flag_mask = 4'hF; ALU_Flags = 4'h9; cycle(); idle_inputs();
        checks++; if (ccr_out !== 4'h2 || depth !== 1) begin errors++; $display("FAIL push_over_wen ccr=%h depth=%0d exp 2/1", ccr_out, depth); end
    endtask

    task automatic test_reset_mid_nest();
        do_reset();
        pop_once();
        write_ccr(4'h7); push_once();
        write_ccr(4'hB); push_once();
        checks++; if (depth !== 2) begin errors++; $display("FAIL mid_depth got %0d exp 2", depth); end
        reset = 1; RTI_en = 1; cycle(); idle_inputs();
        checks++; if (depth !== 0 || ccr_out !== 4'h0) begin errors++; $display("FAIL mid_reset depth=%0d ccr=%h exp 0/0", depth, ccr_out); end
        checks++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin errors++; $display("FAIL mid_reset_err ovf=%b unf=%b exp 0/0", ovf_err, unf_err); end
        // Slots were cleared: force a write of 0 and pop nothing stale by pushing then popping.
        push_once(); write_ccr(4'hE); pop_once();
        checks++; if (ccr_out !== 4'h0) begin errors++; $display("FAIL mid_slot got %h exp 0", ccr_out); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            RTI_en     = ($urandom_range(0, 99) < 25);
            interruptD = ($urandom_range(0, 99) < 40);
            ccr_wen    = ($urandom_range(0, 99) < 60);
            err_clr    = ($urandom_range(0, 99) < 10);
            flag_mask  = 4'($urandom);
            ALU_Flags  = 4'($urandom);
            cycle();
            checks++;
            if (ccr_out !== m_ccr || depth !== DW'(m_depth()) ||
                stack_full !== (m_depth() == DEPTH) || stack_empty !== (m_depth() == 0) ||
                ovf_err !== m_ovf || unf_err !== m_unf) begin
                errors++;
                $display("FAIL rand[%0d] ccr=%h depth=%0d full=%b empty=%b ovf=%b unf=%b exp %h/%0d/%b/%b/%b/%b",
                         n, ccr_out, depth, stack_full, stack_empty, ovf_err, unf_err,
                         m_ccr, m_depth(), m_depth() == DEPTH, m_depth() == 0, m_ovf, m_unf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_flag_write();
        test_nested();
        test_overflow();
        test_underflow();
        test_reset_mid_nest();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccr_stack.md
CCR_STACK -- requirements
Module: ccr_stack

Interface
- REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
- REQ-002 Parameter FLAG_W SHALL default to 4 and set the flag width; bit order is {V, C, N, Z} when FLAG_W=4.
- REQ-003 Parameter DEPTH SHALL default to 4 and set the number of nested interrupt save slots; legal range is 1..16.
- REQ-004 Port clk SHALL be an input, 1 bit: the system clock.
- REQ-005 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
- REQ-006 Port RTI_en SHALL be an input, 1 bit: return from interrupt, which pops the saved CCR.
- REQ-007 Port interruptD SHALL be an input, 1 bit: interrupt detected, which pushes the current CCR.
- REQ-008 Port ccr_wen SHALL be an input, 1 bit: flag update enable.
- REQ-009 Port flag_mask SHALL be an input, FLAG_W bits: per-flag write enable, applied when ccr_wen=1.
- REQ-010 Port ALU_Flags SHALL be an input, FLAG_W bits: new flags from the ALU.
- REQ-011 Port err_clr SHALL be an input, 1 bit: clears the sticky error flags.
- REQ-012 Port ccr_out SHALL be an output, FLAG_W bits: the current CCR.
- REQ-013 Port depth SHALL be an output, $clog2(DEPTH+1) bits: the number of occupied save slots.
- REQ-014 Ports stack_full and stack_empty SHALL be outputs, 1 bit each: depth==DEPTH and depth==0 respectively.
- REQ-015 Ports ovf_err and unf_err SHALL be outputs, 1 bit each: sticky overflow and underflow errors.

Function
- REQ-016 All state SHALL update on the rising edge of clk; every effect SHALL be visible on the outputs one cycle after the request.
- REQ-017 Priority SHALL be reset > RTI_en > interruptD > ccr_wen; each cycle performs only the highest-priority active operation.
- REQ-018 ccr_wen SHALL update each bit independently: ccr_out[i] takes ALU_Flags[i] where flag_mask[i]=1 and holds otherwise.
- REQ-019 interruptD with depth<DEPTH SHALL push the pre-edge ccr_out into slot[depth] and increment depth; ccr_out SHALL be unchanged.
- REQ-020 RTI_en with depth>0 SHALL load ccr_out from slot[depth-1] and decrement depth.
- REQ-021 interruptD with stack_full SHALL drop the push, leave depth, slots and ccr_out unchanged, and set ovf_err.
- REQ-022 RTI_en with stack_empty SHALL leave ccr_out and depth unchanged and set unf_err.
- REQ-023 RTI_en together with interruptD SHALL perform the pop only; the interrupt is ignored that cycle.
- REQ-024 ccr_wen together with RTI_en or interruptD SHALL be ignored, so the saved or restored value is never corrupted.
- REQ-025 err_clr SHALL clear ovf_err and unf_err; an error event in the same cycle SHALL win, leaving the flag set.
- REQ-026 stack_full and stack_empty SHALL be decoded combinationally from the depth register.

Reset
- REQ-027 Reset SHALL set ccr_out=0, depth=0, ovf_err=0 and unf_err=0.
- REQ-028 Reset SHALL clear all slots to 0, and it SHALL override any operation in progress, including a push or pop in the same cycle.

Configuration
- REQ-029 With macro CCR_STACK_ERR_EN defined, the sticky ovf_err/unf_err logic and err_clr SHALL be implemented as above.
- REQ-030 Without CCR_STACK_ERR_EN, ovf_err and unf_err SHALL be tied to 0 and err_clr ignored; overflow and underflow drop behaviour SHALL be unchanged.

Structure
- REQ-031 Shared package ccr_pkg SHALL hold the flag index constants (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3) and the default FLAG_W and DEPTH values.
- REQ-032 The save store SHALL be a sub-module ccr_lifo (push, pop, data in/out, depth, full, empty); the flag masking and priority logic SHALL stay in ccr_stack.

Verification
- REQ-033 Reset then ccr_wen=1, mask=4'b1111, ALU_Flags=4'b1010 -> ccr_out=4'b1010 next cycle, depth=0, stack_empty=1.
- REQ-034 ccr_out=4'b1010, then ccr_wen with mask=4'b0011 and ALU_Flags=4'b0101 -> ccr_out=4'b1001.
- REQ-035 Nested case: push with ccr_out=4'h3, set ccr_out=4'h5, push, set ccr_out=4'hF, RTI, RTI -> ccr_out is 4'h5, then 4'h3; depth goes 1, 2, 1, 0.
- REQ-036 DEPTH=4: five pushes -> depth=4, stack_full=1, ovf_err=1, and the fifth value is not stored; then four RTIs restore the first four values in LIFO order.
- REQ-037 RTI on empty -> unf_err=1 with ccr_out unchanged; err_clr then clears it; err_clr together with RTI on empty leaves unf_err=1; RTI with interruptD and ccr_wen all high -> pop only.
- REQ-038 Reset asserted mid-nest at depth=2 -> depth=0, ccr_out=0, errors cleared; build without CCR_STACK_ERR_EN -> ovf_err and unf_err stay 0 in every scenario.
